dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (dmem: async read, sync write, funct3 sub-word select)

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core and a debug/DMA requester; core wins by default,
// debug is force-granted after MAX_WAIT blocked cycles, and dbg_halt hands debug exclusive use.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_halt,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [2:0]        dbg_funct3,
    output logic              dbg_rvalid,
    input  logic              dbg_rready,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic {ARB = 1'b0, RESP = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic starve;
    logic grant_dbg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        wait_cnt_d = '0;
        case (state_q)
            ARB: begin
                if (grant_dbg) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = dbg_we ? '0 : mem_rd;
                end else if (dbg_valid) begin
                    wait_cnt_d = (wait_cnt_q >= CNT_MAX) ? CNT_MAX : wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (dbg_rready) begin
                    state_d  = ARB;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        starve    = (wait_cnt_q >= CNT_MAX);
        grant_dbg = (state_q == ARB) && dbg_valid && (dbg_halt || !cpu_req || starve);
        dbg_ready = grant_dbg;
        // A stalled core store must never reach memory, including while in RESP under halt.
        if (grant_dbg) begin
            mem_we     = dbg_we & ~reset;
            mem_a      = dbg_addr;
            mem_wd     = dbg_wdata;
            mem_funct3 = dbg_funct3;
        end else begin
            mem_we     = cpu_req & cpu_we & ~dbg_halt & ~reset;
            mem_a      = cpu_addr;
            mem_wd     = cpu_wdata;
            mem_funct3 = cpu_funct3;
        end
        cpu_stall  = dbg_halt | (cpu_req & grant_dbg);
        cpu_rdata  = mem_rd;
        dbg_rvalid = rvalid_q;
        dbg_rdata  = rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small behavioural dmem sits behind the mem_* port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_halt, dbg_valid, dbg_we, dbg_rready;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [2:0]  cpu_funct3, dbg_funct3;
    logic [31:0] cpu_rdata, dbg_rdata, mem_a, mem_wd, mem_rd;
    logic        cpu_stall, dbg_ready, dbg_rvalid, mem_we;
    logic [2:0]  mem_funct3;

    logic [31:0] mem [0:63];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_halt(dbg_halt), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_funct3(dbg_funct3),
        .dbg_rvalid(dbg_rvalid), .dbg_rready(dbg_rready), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 3'b010;
        dbg_halt = 0; dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        dbg_funct3 = 3'b010; dbg_rready = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
        idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wdata = 32'h99;
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b want=0", mem_we); end
        total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b want=0", dbg_rvalid); end
        total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", dbg_rdata); end
        step();
        reset = 0;
        idle();
    endtask

    task automatic test_core_store();
        idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD; cpu_funct3 = 3'b001;
        @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL core_mem_we got=%0b want=1", mem_we); end
        total++; if (mem_a !== 32'h10) begin bad++; $display("FAIL core_mem_a got=%h want=10", mem_a); end
        total++; if (mem_funct3 !== 3'b001) begin bad++; $display("FAIL core_funct3 got=%0d want=1", mem_funct3); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL core_stall got=%0b want=0", cpu_stall); end
        step();
        idle();
        #1;
        total++; if (mem[4] !== 32'hDEAD) begin bad++; $display("FAIL core_mem_content got=%h want=dead", mem[4]); end
    endtask

    task automatic test_dbg_read();
        cpu_store(32'h20, 32'h1234);
        dbg_valid = 1; dbg_addr = 32'h20;
        @(negedge clk);
        total++; if (dbg_ready !== 1'b1) begin bad++; $display("FAIL rd_ready got=%0b want=1", dbg_ready); end
        total++; if (mem_a !== 32'h20) begin bad++; $display("FAIL rd_mem_a got=%h want=20", mem_a); end
        step();
        dbg_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h1234) begin
                bad++; $display("FAIL rd_resp_hold%0d got=%0b/%h want=1/1234", i, dbg_rvalid, dbg_rdata);
            end
            step();
        end
        dbg_rready = 1;
        step();
        dbg_rready = 0;
        @(negedge clk);
        total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rd_retire got=%0b want=0", dbg_rvalid); end
    endtask

    task automatic test_starvation();
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10; dbg_valid = 1; dbg_addr = 32'h20;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            total++; if (dbg_ready !== (c == 8) || cpu_stall !== (c == 8)) begin
                bad++; $display("FAIL starve_cyc%0d got=%0b/%0b want=%0b", c, dbg_ready, cpu_stall, c == 8);
            end
            step();
        end
        @(negedge clk);
        total++; if (dbg_rdata !== 32'h1234 || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL starve_resp got=%h/%0b want=1234/0", dbg_rdata, cpu_stall);
        end
        dbg_valid = 0; dbg_rready = 1;
        step();
        dbg_rready = 0; dbg_valid = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL starve_cnt_clear%0d got=%0b want=0", c, dbg_ready); end
            step();
        end
        idle();
    endtask

    task automatic test_halt_write();
        do_reset();
        cpu_store(32'h40, 32'h1111);
        dbg_halt = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hBAD;
        dbg_valid = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'h55;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b1 || dbg_ready !== 1'b1) begin
            bad++; $display("FAIL halt_grant got=%0b/%0b want=1/1", cpu_stall, dbg_ready);
        end
        total++; if (mem_we !== 1'b1 || mem_a !== 32'h30 || mem_wd !== 32'h55) begin
            bad++; $display("FAIL halt_mem got=%0b/%h/%h want=1/30/55", mem_we, mem_a, mem_wd);
        end
        step();
        dbg_valid = 0;
        @(negedge clk);
        total++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h0) begin
            bad++; $display("FAIL halt_wresp got=%0b/%h want=1/0", dbg_rvalid, dbg_rdata);
        end
        total++; if (mem_we !== 1'b0 || cpu_stall !== 1'b1) begin
            bad++; $display("FAIL halt_resp_idle got=%0b/%0b want=0/1", mem_we, cpu_stall);
        end
        total++; if (mem[12] !== 32'h55 || mem[16] !== 32'h1111) begin
            bad++; $display("FAIL halt_mem_content got=%h/%h want=55/1111", mem[12], mem[16]);
        end
        dbg_rready = 1;
        step();
        idle();
        #1;
        total++; if (mem[16] !== 32'h1111) begin bad++; $display("FAIL halt_no_core_store got=%h want=1111", mem[16]); end
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        dbg_valid = 1; dbg_addr = 32'h20;
        step();
        dbg_valid = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h77;
        @(negedge clk);
        total++; if (dbg_rvalid !== 1'b1) begin bad++; $display("FAIL rst_resp_setup got=%0b want=1", dbg_rvalid); end
        reset = 1;
        #1;
        total++; if (dbg_rvalid !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL rst_resp_clear got=%0b/%0b want=0/0", dbg_rvalid, mem_we);
        end
        step();
        reset = 0;
        dbg_valid = 1;
        @(negedge clk);
        total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL rst_cnt_zero got=%0b want=0", dbg_ready); end
        cpu_req = 0;
        #1;
        total++; if (dbg_ready !== 1'b1) begin bad++; $display("FAIL rst_state_arb got=%0b want=1", dbg_ready); end
        step();
        idle();
        dbg_rready = 1;
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        dbg_valid = 1; dbg_addr = 32'h10;
        step();
        for (int i = 0; i < 5; i++) begin
            cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80 + 32'(i * 4); cpu_wdata = 32'hA0 + 32'(i);
            @(negedge clk);
            total++; if (dbg_ready !== 1'b0 || mem_we !== 1'b1 || cpu_stall !== 1'b0 ||
                         dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEAD) begin
                bad++; $display("FAIL b2b_resp%0d got=%0b/%0b/%0b/%0b/%h want=0/1/0/1/dead",
                                i, dbg_ready, mem_we, cpu_stall, dbg_rvalid, dbg_rdata);
            end
            step();
        end
        cpu_req = 0; cpu_we = 0; dbg_rready = 1;
        @(negedge clk);
        total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL b2b_retire_noaccept got=%0b want=0", dbg_ready); end
        step();
        dbg_rready = 0;
        @(negedge clk);
        total++; if (dbg_ready !== 1'b1 || dbg_rvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_next_accept got=%0b/%0b want=1/0", dbg_ready, dbg_rvalid);
        end
        total++; if (mem[36] !== 32'hA4) begin bad++; $display("FAIL b2b_core_store got=%h want=a4", mem[36]); end
        idle();
        step();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_core_store();
        test_dbg_read();
        test_starvation();
        test_halt_write();
        test_reset_in_resp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
